// File: rtl/la_capture_ctrl_if.sv
// Host-command, probe and capture-FIFO signals of the logic-analyser capture controller.
interface la_capture_ctrl_if #(
  parameter int N_CH = 8
);
  logic [7:0]      rx_data_i;
  logic            rx_rd_i;
  logic [N_CH-1:0] chn_i;
  logic            sample_en_i;
  logic [N_CH-1:0] cap_data_o;
  logic            cap_wr_o;
  logic            cap_full_i;
  logic [1:0]      state_o;
  logic            done_o;
  logic            overrun_o;

  modport slave (
    input  rx_data_i, rx_rd_i, chn_i, sample_en_i, cap_full_i,
    output cap_data_o, cap_wr_o, state_o, done_o, overrun_o
  );

  modport master (
    output rx_data_i, rx_rd_i, chn_i, sample_en_i, cap_full_i,
    input  cap_data_o, cap_wr_o, state_o, done_o, overrun_o
  );
endinterface

// File: rtl/la_capture_ctrl.sv
// Logic-analyser capture controller: byte-command parser, masked trigger and
// post-trigger sample capture into a Tx FIFO with sticky overrun reporting.
module la_capture_ctrl #(
  parameter int N_CH   = 8,
  parameter int N_CNT  = 16,
  parameter int C_POST = 1000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  la_capture_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    P_CMD, P_MASK, P_VAL, P_LSB, P_MSB
  } pstate_t;

  state_t          r_state, w_next;
  pstate_t         r_pstate, w_pnext;
  logic [N_CH-1:0] r_mask, r_value, r_cap_data;
  logic [N_CNT-1:0] r_post, r_remain, w_post_eff;
  logic [7:0]      r_lsb;
  logic            r_cap_wr, r_done, r_overrun;

  logic w_cmd, w_arm_cmd, w_abort, w_cfg_ok, w_arm, w_match, w_trig, w_last;
  logic w_cap_tick, w_wr_next, w_drop;

  // Command decode applies only when the parser is between commands, so an
  // argument byte equal to a command code is never mistaken for one.
  assign w_cmd      = bus.rx_rd_i && (r_pstate == P_CMD);
  assign w_arm_cmd  = w_cmd && (bus.rx_data_i == 8'hA1);
  assign w_abort    = w_cmd && (bus.rx_data_i == 8'hA2);
  assign w_cfg_ok   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_arm      = w_arm_cmd && w_cfg_ok;
  assign w_match    = ((bus.chn_i ^ r_value) & r_mask) == '0;
  assign w_post_eff = (r_post == '0) ? N_CNT'(1) : r_post;
  assign w_trig     = (r_state == S_ARMED) && bus.sample_en_i && w_match && !w_abort;
  assign w_last     = (r_remain <= N_CNT'(1));

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: if (w_arm_cmd) w_next = S_ARMED;
        S_ARMED:        if (w_trig) w_next = (w_post_eff == N_CNT'(1)) ? S_DONE : S_CAPTURE;
        S_CAPTURE:      if (bus.sample_en_i && w_last) w_next = S_DONE;
        default:        w_next = S_IDLE;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_cap_tick = bus.sample_en_i && !w_abort &&
                 (((r_state == S_ARMED) && w_match) || (r_state == S_CAPTURE));
    w_wr_next  = w_cap_tick && !bus.cap_full_i;
    w_drop     = w_cap_tick && bus.cap_full_i;
  end

  always_comb begin
    w_pnext = r_pstate;
    if (bus.rx_rd_i) begin
      case (r_pstate)
        P_CMD: begin
          if (bus.rx_data_i == 8'hB0)      w_pnext = P_MASK;
          else if (bus.rx_data_i == 8'hB1) w_pnext = P_VAL;
          else if (bus.rx_data_i == 8'hC0) w_pnext = P_LSB;
        end
        P_LSB:   w_pnext = P_MSB;
        default: w_pnext = P_CMD;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      r_pstate   <= P_CMD;
      r_mask     <= '0;
      r_value    <= '0;
      r_post     <= N_CNT'(C_POST);
      r_lsb      <= '0;
      r_remain   <= '0;
      r_cap_data <= '0;
      r_cap_wr   <= 1'b0;
      r_done     <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_pstate <= w_pnext;
      if (bus.rx_rd_i) begin
        case (r_pstate)
          P_MASK:  if (w_cfg_ok) r_mask  <= bus.rx_data_i[N_CH-1:0];
          P_VAL:   if (w_cfg_ok) r_value <= bus.rx_data_i[N_CH-1:0];
          P_LSB:   r_lsb <= bus.rx_data_i;
          P_MSB:   if (w_cfg_ok) r_post <= N_CNT'({bus.rx_data_i, r_lsb});
          default: ;
        endcase
      end

      if (w_trig)
        r_remain <= w_post_eff - N_CNT'(1);
      else if ((r_state == S_CAPTURE) && w_cap_tick)
        r_remain <= (r_remain != '0) ? r_remain - N_CNT'(1) : '0;

      if (w_cap_tick) r_cap_data <= bus.chn_i;
      r_cap_wr <= w_wr_next;
      r_done   <= (w_next == S_DONE);

      if (w_arm)       r_overrun <= 1'b0;
      else if (w_drop) r_overrun <= 1'b1;
    end
  end

  assign bus.cap_data_o = r_cap_data;
  assign bus.cap_wr_o   = r_cap_wr;
  assign bus.state_o    = r_state;
  assign bus.done_o     = r_done;
  assign bus.overrun_o  = r_overrun;

endmodule

// File: tb/tb_la_capture_ctrl.sv
// Directed bench for la_capture_ctrl: a per-cycle vector table for the basic
// trigger/capture run plus hand-written multi-cycle sequences.
module tb_la_capture_ctrl;

  logic clk_i;
  logic rst_i;
  la_capture_ctrl_if #(.N_CH(8)) bus ();

  la_capture_ctrl #(.N_CH(8), .N_CNT(16), .C_POST(1000)) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    logic [7:0] chn;
    logic       sen;
    logic       full;
    logic       exp_wr;
    logic [7:0] exp_data;
    logic [1:0] exp_state;
    logic       exp_done;
    logic       exp_ovr;
  } vec_t;

  vec_t       tbl[15];
  logic [7:0] q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  always @(negedge clk_i) if (bus.cap_wr_o === 1'b1) q.push_back(bus.cap_data_o);

  function automatic vec_t v(input logic rd, input logic [7:0] data, input logic [7:0] chn,
                             input logic sen, input logic full, input logic ewr,
                             input logic [7:0] edata, input logic [1:0] est,
                             input logic edone, input logic eovr);
    vec_t r;
    r.rd = rd; r.data = data; r.chn = chn; r.sen = sen; r.full = full;
    r.exp_wr = ewr; r.exp_data = edata; r.exp_state = est; r.exp_done = edone; r.exp_ovr = eovr;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data_i = b;
    bus.rx_rd_i   = 1'b1;
    tick_cyc();
    bus.rx_rd_i   = 1'b0;
  endtask

  task automatic sample(input logic [7:0] c, input logic f);
    bus.chn_i       = c;
    bus.sample_en_i = 1'b1;
    bus.cap_full_i  = f;
    tick_cyc();
    bus.sample_en_i = 1'b0;
    bus.cap_full_i  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = v(1'b1, 8'hB0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tbl[1]  = v(1'b1, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tbl[2]  = v(1'b1, 8'hB1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tbl[3]  = v(1'b1, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tbl[4]  = v(1'b1, 8'hC0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tbl[5]  = v(1'b1, 8'h04, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tbl[6]  = v(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0);
    tbl[7]  = v(1'b1, 8'hA1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0);
    tbl[8]  = v(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 2'd1, 1'b0, 1'b0);
    tbl[9]  = v(1'b0, 8'h00, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 2'd2, 1'b0, 1'b0);
    tbl[10] = v(1'b0, 8'h00, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 2'd2, 1'b0, 1'b0);
    tbl[11] = v(1'b0, 8'h00, 8'h22, 1'b1, 1'b0, 1'b1, 8'h22, 2'd2, 1'b0, 1'b0);
    tbl[12] = v(1'b0, 8'h00, 8'h33, 1'b1, 1'b0, 1'b1, 8'h33, 2'd2, 1'b0, 1'b0);
    tbl[13] = v(1'b0, 8'h00, 8'h44, 1'b1, 1'b0, 1'b1, 8'h44, 2'd3, 1'b1, 1'b0);
    tbl[14] = v(1'b0, 8'h00, 8'h55, 1'b1, 1'b0, 1'b0, 8'h00, 2'd3, 1'b1, 1'b0);

    rst_i = 1'b0;
    bus.rx_data_i = 8'h00; bus.rx_rd_i = 1'b0; bus.chn_i = 8'h00;
    bus.sample_en_i = 1'b0; bus.cap_full_i = 1'b0;
    tick_cyc();
    tick_cyc();
    check("rst_wr",    32'(bus.cap_wr_o),   32'd0);
    check("rst_data",  32'(bus.cap_data_o), 32'd0);
    check("rst_state", 32'(bus.state_o),    32'd0);
    check("rst_done",  32'(bus.done_o),     32'd0);
    check("rst_ovr",   32'(bus.overrun_o),  32'd0);
    rst_i = 1'b1;
    tick_cyc();

    // Trigger on 0x5A with full mask, post_cnt = 4
    for (int i = 0; i < 15; i++) begin
      bus.rx_rd_i = tbl[i].rd; bus.rx_data_i = tbl[i].data; bus.chn_i = tbl[i].chn;
      bus.sample_en_i = tbl[i].sen; bus.cap_full_i = tbl[i].full;
      tick_cyc();
      check($sformatf("vec%0d_wr", i),    32'(bus.cap_wr_o),  32'(tbl[i].exp_wr));
      check($sformatf("vec%0d_state", i), 32'(bus.state_o),   32'(tbl[i].exp_state));
      check($sformatf("vec%0d_done", i),  32'(bus.done_o),    32'(tbl[i].exp_done));
      check($sformatf("vec%0d_ovr", i),   32'(bus.overrun_o), 32'(tbl[i].exp_ovr));
      if (tbl[i].exp_wr) check($sformatf("vec%0d_data", i), 32'(bus.cap_data_o), 32'(tbl[i].exp_data));
    end
    bus.rx_rd_i = 1'b0; bus.sample_en_i = 1'b0;

    // mask=0, post_cnt=0 -> single sample then DONE
    send(8'hB0); send(8'h00);
    send(8'hC0); send(8'h00); send(8'h00);
    send(8'hA1);
    check("p0_armed", 32'(bus.state_o), 32'd1);
    q.delete();
    sample(8'h77, 1'b0);
    check("p0_wr",    32'(bus.cap_wr_o),   32'd1);
    check("p0_data",  32'(bus.cap_data_o), 32'h77);
    check("p0_state", 32'(bus.state_o),    32'd3);
    check("p0_done",  32'(bus.done_o),     32'd1);
    sample(8'h88, 1'b0);
    sample(8'h99, 1'b0);
    check("p0_nwr", 32'(q.size()), 32'd1);

    // post_cnt=8 with FIFO full on samples 3 and 4
    send(8'hC0); send(8'h08); send(8'h00);
    send(8'hA1);
    q.delete();
    for (int i = 1; i <= 8; i++) sample(8'(i), (i == 3) || (i == 4));
    tick_cyc();
    check("ov_state", 32'(bus.state_o),   32'd3);
    check("ov_done",  32'(bus.done_o),    32'd1);
    check("ov_ovr",   32'(bus.overrun_o), 32'd1);
    check("ov_nwr",   32'(q.size()),      32'd6);
    if (q.size() == 6) begin
      check("ov_q0", 32'(q[0]), 32'd1);
      check("ov_q2", 32'(q[2]), 32'd5);
      check("ov_q5", 32'(q[5]), 32'd8);
    end
    send(8'h33);
    check("ov_sticky", 32'(bus.overrun_o), 32'd1);
    send(8'hA1);
    check("ov_clr",   32'(bus.overrun_o), 32'd0);
    check("ov_rearm", 32'(bus.state_o),   32'd1);

    // Abort coincident with a capture tick, then B0 A1 as mask data
    sample(8'h10, 1'b0);
    check("ab_cap", 32'(bus.state_o), 32'd2);
    bus.rx_data_i = 8'hA2; bus.rx_rd_i = 1'b1; bus.chn_i = 8'h20; bus.sample_en_i = 1'b1;
    tick_cyc();
    bus.rx_rd_i = 1'b0; bus.sample_en_i = 1'b0;
    check("ab_wr",    32'(bus.cap_wr_o), 32'd0);
    check("ab_state", 32'(bus.state_o),  32'd0);
    send(8'hB0); send(8'hA1);
    check("ab_argcmd", 32'(bus.state_o), 32'd0);
    send(8'hA1);
    sample(8'h01, 1'b0);
    check("mk_nomatch", 32'(bus.state_o), 32'd1);
    sample(8'h5E, 1'b0);
    check("mk_match", 32'(bus.state_o),    32'd2);
    check("mk_data",  32'(bus.cap_data_o), 32'h5E);
    send(8'hA2);
    check("mk_abort", 32'(bus.state_o), 32'd0);

    // post_cnt write ignored while ARMED; unknown byte ignored in IDLE
    send(8'hA1);
    send(8'hC0); send(8'h10); send(8'h00);
    check("ar_state", 32'(bus.state_o), 32'd1);
    q.delete();
    for (int i = 0; i < 40 && bus.state_o != 2'd3; i++) sample(8'h5E, 1'b0);
    tick_cyc();
    check("ar_done", 32'(bus.state_o), 32'd3);
    check("ar_nwr",  32'(q.size()),    32'd8);
    send(8'hA2);
    send(8'h33);
    check("unk_idle", 32'(bus.state_o), 32'd0);
    send(8'hA1);
    check("unk_arm", 32'(bus.state_o), 32'd1);
    send(8'hA2);

    // Reset in the middle of a capture
    send(8'hA1);
    sample(8'h5E, 1'b0);
    sample(8'h5E, 1'b1);
    check("rc_ovr", 32'(bus.overrun_o), 32'd1);
    sample(8'h66, 1'b0);
    check("rc_wr", 32'(bus.cap_wr_o), 32'd1);
    rst_i = 1'b0;
    bus.rx_data_i = 8'hA1; bus.rx_rd_i = 1'b1; bus.chn_i = 8'h77; bus.sample_en_i = 1'b1;
    tick_cyc();
    check("rc_wr0",    32'(bus.cap_wr_o),   32'd0);
    check("rc_data0",  32'(bus.cap_data_o), 32'd0);
    check("rc_state0", 32'(bus.state_o),    32'd0);
    check("rc_done0",  32'(bus.done_o),     32'd0);
    check("rc_ovr0",   32'(bus.overrun_o),  32'd0);
    rst_i = 1'b1;
    bus.rx_rd_i = 1'b0; bus.sample_en_i = 1'b0;
    q.delete();
    tick_cyc();
    check("rc_idle", 32'(bus.state_o), 32'd0);
    send(8'hA1);
    bus.chn_i = 8'hFF; bus.sample_en_i = 1'b1;
    for (int i = 0; i < 1100 && bus.state_o != 2'd3; i++) tick_cyc();
    bus.sample_en_i = 1'b0;
    tick_cyc();
    check("rc_default_done", 32'(bus.state_o), 32'd3);
    check("rc_default_nwr",  32'(q.size()),    32'd1000);
    if (q.size() > 0) check("rc_first", 32'(q[0]), 32'hFF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
